// File: rtl/definitions_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package definitions_pkg;

  // Parity selection captured at the start of each frame.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } uart_parity_t;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } rx_state_t;

  localparam int DEFAULT_OSR = 16;

  // Mode 2'b11 is reserved and behaves as no parity.
  function automatic uart_parity_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return EVEN;
      2'b10:   return ODD;
      default: return NONE;
    endcase
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous RX line; resets to the idle (high) level.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstN,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the raw line through the flop chain.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) ff <= '1;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receive engine with majority-vote sampling, optional parity,
// one/two stop bits, break detection and a valid/ready holding register.
//
// state    | meaning
// IDLE     | waiting for a falling edge on the synchronised line
// START    | validating the start bit; false starts fall back to IDLE
// DATA     | shifting DATA_W data bits in, LSB first
// PARITY   | sampling the parity bit and computing the parity error
// STOP     | sampling one or two stop bits, then delivering the word
// BRK_WAIT | break seen; waiting for the line to return high
module uart_rx_param
  import definitions_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OSR         = DEFAULT_OSR,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              rx_enabled,
  input  logic              in,
  input  logic              s_tick,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              break_det,
  output logic              overrun,
  output logic              busy
);

  localparam int SW = $clog2(OSR);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [SW-1:0] CNT_LAST  = SW'(OSR - 1);
  localparam logic [SW-1:0] CNT_CHK   = SW'(OSR / 2 - 1);
  localparam logic [SW-1:0] CNT_VOTE  = SW'(OSR / 2 + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);

  logic              rx_s;
  rx_state_t         state, state_n;
  logic [SW-1:0]     s_cnt;
  logic [BW-1:0]     b_cnt;
  logic [1:0]        hist;
  logic              bit_v;
  uart_parity_t      par_q;
  logic              two_q;
  logic [DATA_W-1:0] shreg;
  logic              par_err_q;
  logic              fe_acc;
  logic              low_acc;

  logic              vote_now;
  logic              bit_end;
  logic              start_det;
  logic              frame_done;
  logic              fe_now;
  logic              brk_now;
  logic              load;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rstN (rstN),
    .d    (in),
    .q    (rx_s)
  );

  // Vote over the current sample and the two previous tick samples; at CNT_VOTE this
  // covers counts OSR/2-1..OSR/2+1, at CNT_CHK it covers the three ticks ending there.
  assign vote_now = maj3(hist[1], hist[0], rx_s);
  assign bit_end  = s_tick && (s_cnt == CNT_LAST);
  assign load     = frame_done && (!out_valid || out_ready);

  // Next-state and frame-completion decode.
  always_comb begin
    state_n    = state;
    start_det  = 1'b0;
    frame_done = 1'b0;
    fe_now     = fe_acc | ~bit_v;
    brk_now    = (shreg == '0) && low_acc && !bit_v;
    if (!rx_enabled) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n   = START;
            start_det = 1'b1;
          end
        end
        START: begin
          if (s_tick && (s_cnt == CNT_CHK) && vote_now) state_n = IDLE;
          else if (bit_end)                             state_n = DATA;
        end
        DATA: begin
          if (bit_end && (b_cnt == DATA_LAST))
            state_n = (par_q == NONE) ? STOP : PARITY;
        end
        PARITY: begin
          if (bit_end) state_n = STOP;
        end
        STOP: begin
          if (bit_end && (!two_q || (b_cnt == BW'(1)))) begin
            frame_done = 1'b1;
            state_n    = brk_now ? BRK_WAIT : IDLE;
          end
        end
        BRK_WAIT: begin
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State register, counters, vote capture and the receive shift register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      busy      <= 1'b0;
      s_cnt     <= '0;
      b_cnt     <= '0;
      hist      <= 2'b11;
      bit_v     <= 1'b1;
      par_q     <= NONE;
      two_q     <= 1'b0;
      shreg     <= '0;
      par_err_q <= 1'b0;
      fe_acc    <= 1'b0;
      low_acc   <= 1'b1;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      if (s_tick) hist <= {hist[0], rx_s};
      if (start_det) begin
        s_cnt     <= '0;
        b_cnt     <= '0;
        par_q     <= decode_parity(parity_mode);
        two_q     <= two_stop;
        par_err_q <= 1'b0;
        fe_acc    <= 1'b0;
        low_acc   <= 1'b1;
      end else if ((state != IDLE) && s_tick) begin
        s_cnt <= bit_end ? '0 : s_cnt + 1'b1;
        if (s_cnt == CNT_VOTE) bit_v <= vote_now;
        if (bit_end) begin
          case (state)
            DATA: begin
              shreg <= {bit_v, shreg[DATA_W-1:1]};
              b_cnt <= (b_cnt == DATA_LAST) ? '0 : b_cnt + 1'b1;
            end
            PARITY: par_err_q <= (^shreg) ^ bit_v ^ (par_q == ODD);
            STOP: begin
              fe_acc  <= fe_acc | ~bit_v;
              low_acc <= low_acc & ~bit_v;
              b_cnt   <= b_cnt + 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Output holding register: a completed frame loads only if the slot is free or
  // being drained this cycle; otherwise the old word stays and overrun pulses.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out        <= '0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= frame_done && !load;
      if (load) begin
        out        <= shreg;
        frame_err  <= fe_now;
        parity_err <= par_err_q;
        break_det  <= brk_now;
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8-bit instance and a 7-bit instance share
// control inputs, each with its own RX line. s_tick fires every 4 clocks, OSR=16.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rstN, rx_enabled, in8, in7, s_tick, out_ready, two_stop;
  logic [1:0] parity_mode;

  logic [7:0] out8;
  logic       v8, fe8, pe8, bk8, ov8, busy8;
  logic [6:0] out7;
  logic       v7, fe7, pe7, bk7, ov7, busy7;

  int errors = 0;
  int checks = 0;
  int vrise8 = 0;
  int ovc8   = 0;
  logic v8_prev = 1'b0;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_W(8), .OSR(16), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rstN(rstN), .rx_enabled(rx_enabled), .in(in8), .s_tick(s_tick),
    .parity_mode(parity_mode), .two_stop(two_stop), .out(out8), .out_valid(v8),
    .out_ready(out_ready), .frame_err(fe8), .parity_err(pe8), .break_det(bk8),
    .overrun(ov8), .busy(busy8)
  );

  uart_rx_param #(.DATA_W(7), .OSR(16), .SYNC_STAGES(2)) dut7 (
    .clk(clk), .rstN(rstN), .rx_enabled(rx_enabled), .in(in7), .s_tick(s_tick),
    .parity_mode(parity_mode), .two_stop(two_stop), .out(out7), .out_valid(v7),
    .out_ready(out_ready), .frame_err(fe7), .parity_err(pe7), .break_det(bk7),
    .overrun(ov7), .busy(busy7)
  );

  // Count out_valid rising edges and overrun pulses of the 8-bit instance.
  always @(negedge clk) begin
    if (v8 && !v8_prev) vrise8 = vrise8 + 1;
    v8_prev = v8;
    if (ov8) ovc8 = ovc8 + 1;
  end

  // Oversample strobe: one clock high every four clocks.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait n s_tick pulses, ending on the following falling clock edge.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  // Drive nbits line bits, LSB first, each held for one bit period (16 ticks).
  task automatic send(input bit sel7, input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (sel7) in7 = bits[i];
      else      in8 = bits[i];
      wait_ticks(16);
    end
  endtask

  task automatic wait_valid(input bit sel7, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (sel7 ? v7 : v8) seen = 1'b1;
      else                @(negedge clk);
    end
  endtask

  initial begin
    bit seen;
    int base_v, base_ov;

    rstN = 1'b0; rx_enabled = 1'b1; in8 = 1'b1; in7 = 1'b1;
    out_ready = 1'b1; parity_mode = 2'b00; two_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out",       out8,  8'h00);
    check("rst_valid",     v8,    1'b0);
    check("rst_frame_err", fe8,   1'b0);
    check("rst_par_err",   pe8,   1'b0);
    check("rst_break",     bk8,   1'b0);
    check("rst_overrun",   ov8,   1'b0);
    check("rst_busy",      busy8, 1'b0);
    check("rst_busy7",     busy7, 1'b0);
    check("rst_overrun7",  ov7,   1'b0);
    rstN = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5
    send(1'b0, {6'h3F, 1'b1, 8'hA5, 1'b0}, 10);
    wait_valid(1'b0, seen);
    check("a5_seen",      seen, 1'b1);
    check("a5_out",       out8, 8'hA5);
    check("a5_frame_err", fe8,  1'b0);
    check("a5_par_err",   pe8,  1'b0);
    check("a5_break",     bk8,  1'b0);
    @(negedge clk);
    check("a5_valid_1clk", v8, 1'b0);
    repeat (4) @(negedge clk);
    check("a5_busy_idle", busy8, 1'b0);

    // 7 data bits, even parity, wrong parity bit (correct would be 0)
    parity_mode = 2'b01;
    send(1'b1, {6'h3F, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
    wait_valid(1'b1, seen);
    check("even_seen",      seen, 1'b1);
    check("even_out",       out7, 7'h41);
    check("even_par_err",   pe7,  1'b1);
    check("even_frame_err", fe7,  1'b0);
    check("even_break",     bk7,  1'b0);

    // Same frame under odd parity: parity bit 1 is correct
    parity_mode = 2'b10;
    repeat (8) @(negedge clk);
    send(1'b1, {6'h3F, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
    wait_valid(1'b1, seen);
    check("odd_seen",    seen, 1'b1);
    check("odd_out",     out7, 7'h41);
    check("odd_par_err", pe7,  1'b0);
    parity_mode = 2'b00;
    repeat (8) @(negedge clk);

    // 4-tick glitch: false start
    base_v = vrise8;
    in8 = 1'b0;
    wait_ticks(4);
    check("glitch_busy_hi", busy8, 1'b1);
    in8 = 1'b1;
    wait_ticks(6);
    check("glitch_busy_lo", busy8, 1'b0);
    wait_ticks(40);
    check("glitch_no_word", vrise8 - base_v, 0);

    // Break: all-zero data, stop low, line low for 3 more bit times
    send(1'b0, 16'h0000, 10);
    wait_valid(1'b0, seen);
    check("brk_seen",      seen, 1'b1);
    check("brk_out",       out8, 8'h00);
    check("brk_break",     bk8,  1'b1);
    check("brk_frame_err", fe8,  1'b1);
    check("brk_par_err",   pe8,  1'b0);
    wait_ticks(40);
    check("brk_busy_held", busy8, 1'b1);
    in8 = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_busy_rel", busy8, 1'b0);

    // Overrun with out_ready low
    out_ready = 1'b0;
    base_ov = ovc8;
    send(1'b0, {6'h3F, 1'b1, 8'h11, 1'b0}, 10);
    wait_valid(1'b0, seen);
    check("ovr_seen1", seen, 1'b1);
    check("ovr_out1",  out8, 8'h11);
    check("ovr_ov_first", ovc8 - base_ov, 0);
    send(1'b0, {6'h3F, 1'b1, 8'h22, 1'b0}, 10);
    wait_ticks(3);
    check("ovr_out_kept", out8, 8'h11);
    check("ovr_valid",    v8,   1'b1);
    check("ovr_pulses",   ovc8 - base_ov, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("ovr_drained", v8, 1'b0);

    // rx_enabled dropped mid-frame
    base_v = vrise8;
    in8 = 1'b0;
    wait_ticks(20);
    check("abort_busy_hi", busy8, 1'b1);
    rx_enabled = 1'b0;
    @(negedge clk);
    check("abort_busy_lo", busy8, 1'b0);
    in8 = 1'b1;
    wait_ticks(20);
    rx_enabled = 1'b1;
    wait_ticks(4);
    check("abort_no_word", vrise8 - base_v, 0);
    check("abort_out",     out8, 8'h11);

    // Two stop bits, second stop low
    two_stop = 1'b1;
    send(1'b0, {5'h1F, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    in8 = 1'b1;
    wait_valid(1'b0, seen);
    check("two_seen",      seen, 1'b1);
    check("two_out",       out8, 8'h3C);
    check("two_frame_err", fe8,  1'b1);
    check("two_par_err",   pe8,  1'b0);
    check("two_break",     bk8,  1'b0);
    repeat (4) @(negedge clk);

    // Reset mid-frame
    in8 = 1'b0;
    wait_ticks(40);
    check("mid_busy", busy8, 1'b1);
    rstN = 1'b0;
    @(negedge clk);
    in8 = 1'b1;
    check("inrst_out",       out8,  8'h00);
    check("inrst_frame_err", fe8,   1'b0);
    check("inrst_busy",      busy8, 1'b0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (5) @(negedge clk);
    check("post_out",       out8,  8'h00);
    check("post_valid",     v8,    1'b0);
    check("post_frame_err", fe8,   1'b0);
    check("post_par_err",   pe8,   1'b0);
    check("post_break",     bk8,   1'b0);
    check("post_overrun",   ov8,   1'b0);
    check("post_busy",      busy8, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
